fetch_decode_stage: RTL and testbench

FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

---
 rtl/fetch_decode_pkg.sv | 9 +
 rtl/fetch_decode_stage_imm_gen.sv | 16 +
 rtl/fetch_decode_stage.sv | 111 +++++++++++
 tb/tb_fetch_decode_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: opcodes, ALU/immediate selectors and FSM state shared by the fetch/decode slice
package fetch_decode_pkg;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   typedef enum logic [2:0] {ADD = 3'b000, SUB = 3'b001} alu_ctrl_e;
   typedef enum logic {IMM_I, IMM_B} imm_src_e;
   typedef enum logic {RUN, HALT} state_e;
endpackage

// File: rtl/fetch_decode_stage_imm_gen.sv
// imm_gen: sign-extends the I- or B-format immediate of an instruction word
module imm_gen
   import fetch_decode_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic                  imm_src_i,
   output logic [DATA_WIDTH-1:0] imm_o
);
   // B-format scatters imm[11:1] across the word; bit 0 is always zero
   always_comb
      imm_o = (imm_src_i == IMM_B)
            ? {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}
            : {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC/fetch plus IF/ID decode with branch redirect; FETCH_DECODE_ILLEGAL_TRAP_EN adds halt-on-illegal
module fetch_decode_stage
   import fetch_decode_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int REG_ADDRESS_WIDTH = 5,
   parameter int MEM_ADDRESS_WIDTH = 8,
   parameter int RESET_PC          = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [MEM_ADDRESS_WIDTH-1:0] instr_addr,
   input  logic [DATA_WIDTH-1:0]        instr_rdata,
   input  logic                         stall,
   input  logic                         EQ,
   output logic                         dec_valid,
   output logic [MEM_ADDRESS_WIDTH-1:0] dec_pc,
   output logic [DATA_WIDTH-1:0]        ImmOp,
   output logic                         ALUsrc,
   output logic [2:0]                   ALUctrl,
   output logic                         RegWrite,
   output logic [REG_ADDRESS_WIDTH-1:0] rs1,
   output logic [REG_ADDRESS_WIDTH-1:0] rs2,
   output logic [REG_ADDRESS_WIDTH-1:0] rd,
   output logic                         halted
);
   logic [MEM_ADDRESS_WIDTH-1:0] pc_q, pc_d, dpc_q, dpc_d, target;
   logic [DATA_WIDTH-1:0]        instr_q, instr_d, imm;
   logic                         valid_q, valid_d;
   logic [6:0]                   opcode, funct7;
   logic [2:0]                   funct3;
   logic                         is_addi, is_alu, is_br, illegal, taken, freeze, imm_src;

   assign opcode  = instr_q[6:0];
   assign funct3  = instr_q[14:12];
   assign funct7  = instr_q[31:25];
   assign is_addi = opcode == OP_IMM && funct3 == 3'b000;
   assign is_alu  = opcode == OP && funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
   assign is_br   = opcode == BRANCH && funct3[2:1] == 2'b00;
   assign illegal = !(is_addi || is_alu || is_br);
   assign imm_src = is_br ? IMM_B : IMM_I;

   imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
      .instr_i  (instr_q),
      .imm_src_i(imm_src),
      .imm_o    (imm)
   );

   assign ImmOp      = illegal ? '0 : imm;
   assign ALUsrc     = is_addi;
   assign ALUctrl    = (is_br || (is_alu && funct7[5])) ? SUB : ADD;
   assign RegWrite   = valid_q && (is_addi || is_alu);
   assign rs1        = REG_ADDRESS_WIDTH'(instr_q[19:15]);
   assign rs2        = REG_ADDRESS_WIDTH'(instr_q[24:20]);
   assign rd         = REG_ADDRESS_WIDTH'(instr_q[11:7]);
   assign instr_addr = pc_q;
   assign dec_valid  = valid_q;
   assign dec_pc     = dpc_q;
   assign taken      = valid_q && !stall && is_br && (funct3[0] ^ EQ);
   assign target     = dpc_q + ImmOp[MEM_ADDRESS_WIDTH-1:0];

`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
   state_e state_q;
   logic   halted_q, trap;
   assign trap   = state_q == RUN && valid_q && illegal && !stall;
   assign freeze = state_q == HALT || trap;
   assign halted = halted_q;
   // RUN -> HALT on a committed illegal instruction; only reset leaves HALT
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
      end else if (trap) begin
         state_q  <= HALT;
         halted_q <= 1'b1;
      end
`else
   assign freeze = 1'b0;
   assign halted = 1'b0;
`endif

   // stall holds everything; a taken branch redirects PC and turns the wrong-path fetch into a bubble
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      dpc_d   = dpc_q;
      valid_d = valid_q;
      if (freeze)
         valid_d = 1'b0;
      else if (!stall) begin
         pc_d    = taken ? target : pc_q + MEM_ADDRESS_WIDTH'(4);
         instr_d = instr_rdata;
         dpc_d   = pc_q;
         valid_d = !taken;
      end
   end

   // PC and IF/ID register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc_q    <= MEM_ADDRESS_WIDTH'(RESET_PC);
         instr_q <= '0;
         dpc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         dpc_q   <= dpc_d;
         valid_q <= valid_d;
      end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed checks of fetch, decode, branch, stall, wrap and illegal handling (FETCH_DECODE_ILLEGAL_TRAP_EN aware)
module tb_fetch_decode_stage;
   logic        clk = 1'b0, rst_n, stall, EQ;
   logic [7:0]  instr_addr, dec_pc;
   logic [31:0] instr_rdata, ImmOp;
   logic        dec_valid, ALUsrc, RegWrite, halted;
   logic [2:0]  ALUctrl;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] mem [0:63];
   int          checks = 0, errors = 0;

   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] ADDR = 32'h002081B3;
   localparam logic [31:0] SUBR = 32'h40208233;
   localparam logic [31:0] MULR = 32'h022081B3;
   localparam logic [31:0] BNE  = 32'hFE009CE3;
   localparam logic [31:0] ILL  = 32'hFFFFFFFF;

   fetch_decode_stage dut (
      .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
      .stall(stall), .EQ(EQ), .dec_valid(dec_valid), .dec_pc(dec_pc), .ImmOp(ImmOp),
      .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .RegWrite(RegWrite), .rs1(rs1), .rs2(rs2),
      .rd(rd), .halted(halted)
   );

   assign instr_rdata = mem[instr_addr[7:2]];
   always #5 clk = ~clk;

   task automatic load_nops;
      for (int i = 0; i < 64; i++) mem[i] = NOP;
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      load_nops();
      mem[0] = ADDI;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (instr_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", instr_addr); end
      checks++; if ({dec_valid, RegWrite, ALUsrc, ALUctrl} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {dec_valid, RegWrite, ALUsrc, ALUctrl}); end
      checks++; if (ImmOp !== 32'd0) begin errors++; $display("FAIL reset_imm: got %h expected 0", ImmOp); end
      checks++; if ({rs1, rs2, rd, halted} !== 16'd0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {rs1, rs2, rd, halted}); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_seq;
      load_nops();
      do_reset();
      checks++; if ({instr_addr, dec_valid} !== {8'd0, 1'b0}) begin errors++; $display("FAIL seq0: got addr %0d valid %b expected 0 0", instr_addr, dec_valid); end
      step();
      checks++; if ({instr_addr, dec_pc, dec_valid} !== {8'd4, 8'd0, 1'b1}) begin errors++; $display("FAIL seq1: got %0d %0d %b expected 4 0 1", instr_addr, dec_pc, dec_valid); end
      step();
      checks++; if ({instr_addr, dec_pc, dec_valid} !== {8'd8, 8'd4, 1'b1}) begin errors++; $display("FAIL seq2: got %0d %0d %b expected 8 4 1", instr_addr, dec_pc, dec_valid); end
   endtask

   task automatic test_addi;
      load_nops();
      mem[0] = ADDI;
      do_reset();
      step();
      checks++; if (ImmOp !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h expected 5", ImmOp); end
      checks++; if ({ALUsrc, ALUctrl, RegWrite} !== 5'b1_000_1) begin errors++; $display("FAIL addi_ctrl: got %b expected 10001", {ALUsrc, ALUctrl, RegWrite}); end
      checks++; if ({rd, rs1} !== {5'd1, 5'd0}) begin errors++; $display("FAIL addi_regs: got rd %0d rs1 %0d expected 1 0", rd, rs1); end
   endtask

   task automatic test_back_to_back;
      load_nops();
      mem[0] = ADDR;
      mem[1] = SUBR;
      mem[2] = MULR;
      do_reset();
      step();
      checks++; if ({ALUsrc, ALUctrl, RegWrite} !== 5'b0_000_1) begin errors++; $display("FAIL add_ctrl: got %b expected 00001", {ALUsrc, ALUctrl, RegWrite}); end
      checks++; if ({rs1, rs2, rd} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_regs: got %0d %0d %0d expected 1 2 3", rs1, rs2, rd); end
      step();
      checks++; if ({ALUsrc, ALUctrl, RegWrite, rd} !== {5'b0_001_1, 5'd4}) begin errors++; $display("FAIL sub_ctrl: got %b rd %0d expected 00011 rd 4", {ALUsrc, ALUctrl, RegWrite}, rd); end
      step();
      checks++; if ({ALUsrc, ALUctrl, RegWrite, ImmOp} !== {5'b0, 32'd0}) begin errors++; $display("FAIL badfunct_nop: got %b imm %h expected 00000 imm 0", {ALUsrc, ALUctrl, RegWrite}, ImmOp); end
   endtask

   task automatic test_branch_taken;
      load_nops();
      mem[3] = BNE;
      EQ = 1'b0;
      do_reset();
      repeat (4) step();
      checks++; if ({instr_addr, dec_pc} !== {8'd16, 8'd12}) begin errors++; $display("FAIL br_in_d: got %0d %0d expected 16 12", instr_addr, dec_pc); end
      checks++; if ({ImmOp, ALUctrl, RegWrite, ALUsrc} !== {32'hFFFFFFF8, 3'b001, 1'b0, 1'b0}) begin errors++; $display("FAIL br_decode: got imm %h ctrl %b rw %b src %b expected fffffff8 001 0 0", ImmOp, ALUctrl, RegWrite, ALUsrc); end
      step();
      checks++; if ({instr_addr, dec_valid} !== {8'd4, 1'b0}) begin errors++; $display("FAIL br_redirect: got %0d valid %b expected 4 0", instr_addr, dec_valid); end
      step();
      checks++; if ({instr_addr, dec_pc, dec_valid} !== {8'd8, 8'd4, 1'b1}) begin errors++; $display("FAIL br_target_dec: got %0d %0d %b expected 8 4 1", instr_addr, dec_pc, dec_valid); end
   endtask

   task automatic test_branch_not_taken;
      load_nops();
      mem[3] = BNE;
      EQ = 1'b1;
      do_reset();
      repeat (5) step();
      checks++; if ({instr_addr, dec_pc, dec_valid} !== {8'd20, 8'd16, 1'b1}) begin errors++; $display("FAIL br_not_taken: got %0d %0d %b expected 20 16 1", instr_addr, dec_pc, dec_valid); end
      EQ = 1'b0;
   endtask

   task automatic test_stall;
      load_nops();
      mem[3] = BNE;
      EQ = 1'b0;
      do_reset();
      repeat (4) step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({instr_addr, dec_pc, dec_valid} !== {8'd16, 8'd12, 1'b1}) begin errors++; $display("FAIL stall_hold%0d: got %0d %0d %b expected 16 12 1", i, instr_addr, dec_pc, dec_valid); end
      end
      stall = 1'b0;
      step();
      checks++; if ({instr_addr, dec_valid} !== {8'd4, 1'b0}) begin errors++; $display("FAIL stall_release: got %0d valid %b expected 4 0", instr_addr, dec_valid); end
   endtask

   task automatic test_wrap;
      load_nops();
      do_reset();
      repeat (63) step();
      checks++; if (instr_addr !== 8'd252) begin errors++; $display("FAIL wrap_pre: got %0d expected 252", instr_addr); end
      step();
      checks++; if ({instr_addr, dec_pc} !== {8'd0, 8'd252}) begin errors++; $display("FAIL wrap: got %0d %0d expected 0 252", instr_addr, dec_pc); end
   endtask

   task automatic test_illegal;
      load_nops();
      mem[2] = ILL;
      do_reset();
      repeat (3) step();
      checks++; if ({dec_pc, dec_valid, ALUsrc, ALUctrl, RegWrite, ImmOp} !== {8'd8, 1'b1, 5'b0, 32'd0}) begin errors++; $display("FAIL ill_decode: got pc %0d v %b ctrl %b imm %h expected 8 1 00000 0", dec_pc, dec_valid, {ALUsrc, ALUctrl, RegWrite}, ImmOp); end
      step();
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
      checks++; if ({halted, instr_addr, dec_valid} !== {1'b1, 8'd12, 1'b0}) begin errors++; $display("FAIL ill_halt: got h %b addr %0d v %b expected 1 12 0", halted, instr_addr, dec_valid); end
      step();
      checks++; if ({halted, instr_addr, RegWrite} !== {1'b1, 8'd12, 1'b0}) begin errors++; $display("FAIL ill_frozen: got h %b addr %0d rw %b expected 1 12 0", halted, instr_addr, RegWrite); end
`else
      checks++; if ({halted, instr_addr, dec_pc, dec_valid} !== {1'b0, 8'd16, 8'd12, 1'b1}) begin errors++; $display("FAIL ill_continue: got h %b %0d %0d %b expected 0 16 12 1", halted, instr_addr, dec_pc, dec_valid); end
      step();
      checks++; if ({halted, instr_addr} !== {1'b0, 8'd20}) begin errors++; $display("FAIL ill_continue2: got h %b %0d expected 0 20", halted, instr_addr); end
`endif
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({instr_addr, halted, dec_valid} !== {8'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL ill_reset: got %0d h %b v %b expected 0 0 0", instr_addr, halted, dec_valid); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if ({instr_addr, dec_valid} !== {8'd4, 1'b1}) begin errors++; $display("FAIL ill_restart: got %0d v %b expected 4 1", instr_addr, dec_valid); end
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      EQ    = 1'b0;
      test_reset();
      test_seq();
      test_addi();
      test_back_to_back();
      test_branch_taken();
      test_branch_not_taken();
      test_stall();
      test_wrap();
      test_illegal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
